testio_wb_arbiter: RTL and testbench

- Two-master Wishbone arbiter sharing the single on-chip Wishbone slave bus between the testio slave's master port (master 0) and the core's data master port (master 1).
- Grants one master at a time and holds the grant for the whole cycle.
- Routes ack and read data back to the granted master only.
- A watchdog terminates stalled cycles so the testio serial link never hangs waiting for an ack.

---
 rtl/testio_wb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_testio_wb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/testio_wb_arbiter.sv
// ============================================================================
// Module   : testio_wb_arbiter
// Purpose  : Two-master Wishbone arbiter (testio master 0, core master 1)
//            with a stalled-cycle watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module testio_wb_arbiter #(
    parameter int unsigned          BUS_WIDTH = 32,
    parameter int unsigned          RR_EN     = 0,
    parameter int unsigned          TMO_W     = 8,
    parameter int unsigned          TMO_CYC   = 200,
    parameter logic [BUS_WIDTH-1:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   m0_wbs_cyc_i,
    input  logic                   m0_wbs_stb_i,
    input  logic                   m0_wbs_we_i,
    input  logic [BUS_WIDTH-1:0]   m0_wbs_addr_i,
    input  logic [BUS_WIDTH-1:0]   m0_wbs_wdata_i,
    input  logic [BUS_WIDTH/8-1:0] m0_wbs_strb_i,
    output logic                   m0_wbs_ack_o,
    output logic [BUS_WIDTH-1:0]   m0_wbs_rdata_o,

    input  logic                   m1_wbs_cyc_i,
    input  logic                   m1_wbs_stb_i,
    input  logic                   m1_wbs_we_i,
    input  logic [BUS_WIDTH-1:0]   m1_wbs_addr_i,
    input  logic [BUS_WIDTH-1:0]   m1_wbs_wdata_i,
    input  logic [BUS_WIDTH/8-1:0] m1_wbs_strb_i,
    output logic                   m1_wbs_ack_o,
    output logic [BUS_WIDTH-1:0]   m1_wbs_rdata_o,

    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [BUS_WIDTH-1:0]   wbm_addr_o,
    output logic [BUS_WIDTH-1:0]   wbm_wdata_o,
    output logic [BUS_WIDTH/8-1:0] wbm_strb_o,
    input  logic                   wbm_ack_i,
    input  logic [BUS_WIDTH-1:0]   wbm_rdata_i,

    output logic                   tmo_flag_o,
    output logic [7:0]             tmo_cnt_o
);

    localparam bit               WDOG_EN  = (TMO_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = WDOG_EN ? TMO_W'(TMO_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2,
        S_TMO  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [TMO_W-1:0] wd_q, wd_d;
    logic             tmo_who_q, tmo_who_d;
    logic             tmo_flag_q, tmo_flag_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;

    logic                   req0, req1;
    logic                   gnt1;
    logic                   sel_cyc, sel_stb, sel_we;
    logic [BUS_WIDTH-1:0]   sel_addr, sel_wdata;
    logic [BUS_WIDTH/8-1:0] sel_strb;

    assign req0 = m0_wbs_cyc_i & m0_wbs_stb_i;
    assign req1 = m1_wbs_cyc_i & m1_wbs_stb_i;
    assign gnt1 = (state_q == S_GNT1);

    // Master-side mux; only consumed while in a grant state.
    assign sel_cyc   = gnt1 ? m1_wbs_cyc_i   : m0_wbs_cyc_i;
    assign sel_stb   = gnt1 ? m1_wbs_stb_i   : m0_wbs_stb_i;
    assign sel_we    = gnt1 ? m1_wbs_we_i    : m0_wbs_we_i;
    assign sel_addr  = gnt1 ? m1_wbs_addr_i  : m0_wbs_addr_i;
    assign sel_wdata = gnt1 ? m1_wbs_wdata_i : m0_wbs_wdata_i;
    assign sel_strb  = gnt1 ? m1_wbs_strb_i  : m0_wbs_strb_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            wd_q       <= '0;
            tmo_who_q  <= 1'b0;
            tmo_flag_q <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wd_q       <= wd_d;
            tmo_who_q  <= tmo_who_d;
            tmo_flag_q <= tmo_flag_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        wd_d           = '0;
        tmo_who_d      = tmo_who_q;
        tmo_flag_d     = tmo_flag_q;
        tmo_cnt_d      = tmo_cnt_q;

        wbm_cyc_o      = 1'b0;
        wbm_stb_o      = 1'b0;
        wbm_we_o       = 1'b0;
        wbm_addr_o     = '0;
        wbm_wdata_o    = '0;
        wbm_strb_o     = '0;
        m0_wbs_ack_o   = 1'b0;
        m0_wbs_rdata_o = '0;
        m1_wbs_ack_o   = 1'b0;
        m1_wbs_rdata_o = '0;

        case (state_q)
            S_IDLE: begin
                if (req0 && req1) begin
                    state_d = ((RR_EN != 0) && !last_q) ? S_GNT1 : S_GNT0;
                end else if (req0) begin
                    state_d = S_GNT0;
                end else if (req1) begin
                    state_d = S_GNT1;
                end
            end

            S_GNT0, S_GNT1: begin
                wbm_cyc_o   = sel_cyc;
                wbm_stb_o   = sel_stb;
                wbm_we_o    = sel_we;
                wbm_addr_o  = sel_addr;
                wbm_wdata_o = sel_wdata;
                wbm_strb_o  = sel_strb;
                if (gnt1) begin
                    m1_wbs_ack_o   = wbm_ack_i;
                    m1_wbs_rdata_o = wbm_rdata_i;
                end else begin
                    m0_wbs_ack_o   = wbm_ack_i;
                    m0_wbs_rdata_o = wbm_rdata_i;
                end

                // An ack in the same cycle as the limit completes normally.
                if (!sel_cyc) begin
                    state_d = S_IDLE;
                    last_d  = gnt1;
                end else if (!wbm_ack_i && sel_stb && WDOG_EN) begin
                    if (wd_q == TMO_LAST) begin
                        state_d    = S_TMO;
                        tmo_who_d  = gnt1;
                        tmo_flag_d = 1'b1;
                        tmo_cnt_d  = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end

            S_TMO: begin
                // Synthetic error completion; the real slave ack is ignored.
                if (tmo_who_q) begin
                    m1_wbs_ack_o   = 1'b1;
                    m1_wbs_rdata_o = ERR_DATA;
                end else begin
                    m0_wbs_ack_o   = 1'b1;
                    m0_wbs_rdata_o = ERR_DATA;
                end
                state_d = S_IDLE;
                last_d  = tmo_who_q;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign tmo_flag_o = tmo_flag_q;
    assign tmo_cnt_o  = tmo_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_testio_wb_arbiter.sv
// Directed bench for testio_wb_arbiter: a fixed-priority instance (a_*) and a
// round-robin instance (b_*) share all inputs; both use an 8-cycle watchdog.
`default_nettype none

module tb_testio_wb_arbiter;

    localparam logic [31:0] A0  = 32'h1000_0010;
    localparam logic [31:0] A1  = 32'h2000_0020;
    localparam logic [31:0] RD  = 32'h1234_5678;
    localparam logic [31:0] RD1 = 32'hAAAA_5555;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_strb, m1_strb;
    logic        wbm_ack;
    logic [31:0] wbm_rdata;

    logic        a_m0_ack, a_m1_ack, a_cyc, a_stb, a_we, a_flag;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_addr, a_wdata;
    logic [3:0]  a_strb;
    logic [7:0]  a_cnt;
    logic        b_m0_ack, b_m1_ack, b_cyc, b_stb, b_we, b_flag;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_addr, b_wdata;
    logic [3:0]  b_strb;
    logic [7:0]  b_cnt;

    testio_wb_arbiter #(.BUS_WIDTH(32), .RR_EN(0), .TMO_W(8), .TMO_CYC(8), .ERR_DATA(32'hDEAD_BEEF)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .m0_wbs_cyc_i(m0_cyc), .m0_wbs_stb_i(m0_stb), .m0_wbs_we_i(m0_we), .m0_wbs_addr_i(m0_addr),
        .m0_wbs_wdata_i(m0_wdata), .m0_wbs_strb_i(m0_strb), .m0_wbs_ack_o(a_m0_ack), .m0_wbs_rdata_o(a_m0_rdata),
        .m1_wbs_cyc_i(m1_cyc), .m1_wbs_stb_i(m1_stb), .m1_wbs_we_i(m1_we), .m1_wbs_addr_i(m1_addr),
        .m1_wbs_wdata_i(m1_wdata), .m1_wbs_strb_i(m1_strb), .m1_wbs_ack_o(a_m1_ack), .m1_wbs_rdata_o(a_m1_rdata),
        .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_we_o(a_we), .wbm_addr_o(a_addr), .wbm_wdata_o(a_wdata),
        .wbm_strb_o(a_strb), .wbm_ack_i(wbm_ack), .wbm_rdata_i(wbm_rdata),
        .tmo_flag_o(a_flag), .tmo_cnt_o(a_cnt)
    );

    testio_wb_arbiter #(.BUS_WIDTH(32), .RR_EN(1), .TMO_W(8), .TMO_CYC(8), .ERR_DATA(32'hDEAD_BEEF)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_wbs_cyc_i(m0_cyc), .m0_wbs_stb_i(m0_stb), .m0_wbs_we_i(m0_we), .m0_wbs_addr_i(m0_addr),
        .m0_wbs_wdata_i(m0_wdata), .m0_wbs_strb_i(m0_strb), .m0_wbs_ack_o(b_m0_ack), .m0_wbs_rdata_o(b_m0_rdata),
        .m1_wbs_cyc_i(m1_cyc), .m1_wbs_stb_i(m1_stb), .m1_wbs_we_i(m1_we), .m1_wbs_addr_i(m1_addr),
        .m1_wbs_wdata_i(m1_wdata), .m1_wbs_strb_i(m1_strb), .m1_wbs_ack_o(b_m1_ack), .m1_wbs_rdata_o(b_m1_rdata),
        .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we), .wbm_addr_o(b_addr), .wbm_wdata_o(b_wdata),
        .wbm_strb_o(b_strb), .wbm_ack_i(wbm_ack), .wbm_rdata_i(wbm_rdata),
        .tmo_flag_o(b_flag), .tmo_cnt_o(b_cnt)
    );

    // The slave model and the arbitration loop follow whichever instance is selected.
    logic        sel_b;
    logic        s_cyc, s_stb, s_m0_ack, s_m1_ack;
    logic [31:0] s_addr, s_m0_rdata, s_m1_rdata;
    assign s_cyc      = sel_b ? b_cyc      : a_cyc;
    assign s_stb      = sel_b ? b_stb      : a_stb;
    assign s_addr     = sel_b ? b_addr     : a_addr;
    assign s_m0_ack   = sel_b ? b_m0_ack   : a_m0_ack;
    assign s_m1_ack   = sel_b ? b_m1_ack   : a_m1_ack;
    assign s_m0_rdata = sel_b ? b_m0_rdata : a_m0_rdata;
    assign s_m1_rdata = sel_b ? b_m1_rdata : a_m1_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int grants[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = A0; m0_wdata = 32'h0000_00A0; m0_strb = 4'hF;
        m1_cyc = 0; m1_stb = 0; m1_we = 1; m1_addr = A1; m1_wdata = 32'h0000_00A1; m1_strb = 4'h3;
        wbm_ack = 0; wbm_rdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic        r0, r1, ack;
        logic [31:0] rdata;
        logic        e_cyc;
        logic [31:0] e_addr;
        logic        e_a0;
        logic [31:0] e_d0;
        logic        e_a1;
        logic [31:0] e_d1;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic r1, input logic ack, input logic [31:0] rdata,
                                input logic e_cyc, input logic [31:0] e_addr, input logic e_a0,
                                input logic [31:0] e_d0, input logic e_a1, input logic [31:0] e_d1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.ack = ack; v.rdata = rdata; v.e_cyc = e_cyc; v.e_addr = e_addr;
        v.e_a0 = e_a0; v.e_d0 = e_d0; v.e_a1 = e_a1; v.e_d1 = e_d1;
        return v;
    endfunction

    // Two masters doing single-beat writes; a master drops cyc for one cycle after each ack.
    task automatic run_arb(input int n0, input int n1);
        int  left0, left1, cyc, last_ack;
        bit  act0, act1, got0, got1;
        left0 = n0; left1 = n1; act0 = (n0 > 0); act1 = (n1 > 0);
        cyc = 0; last_ack = -1;
        grants.delete();
        while ((left0 > 0 || left1 > 0) && cyc < 100) begin
            m0_cyc = act0; m0_stb = act0; m0_we = 1; m0_addr = 32'h1000_0000 + 32'(left0);
            m1_cyc = act1; m1_stb = act1; m1_we = 1; m1_addr = 32'h2000_0000 + 32'(left1);
            wbm_ack = 0;
            #1;
            wbm_ack   = s_cyc & s_stb;
            wbm_rdata = s_addr ^ KEY;
            #2;
            got0 = s_m0_ack; got1 = s_m1_ack;
            if (got0 || got1) begin
                check("single_ack", {31'b0, got0 & got1}, 32'd0);
                if (last_ack >= 0) check("grant_gap", 32'(cyc - last_ack), 32'd3);
                last_ack = cyc;
                if (got0) begin
                    check("m0_rdata", s_m0_rdata, m0_addr ^ KEY);
                    grants.push_back(0);
                end else begin
                    check("m1_rdata", s_m1_rdata, m1_addr ^ KEY);
                    grants.push_back(1);
                end
            end
            step();
            cyc++;
            if (got0) begin act0 = 0; left0--; end else if (!act0 && left0 > 0) act0 = 1;
            if (got1) begin act1 = 0; left1--; end else if (!act1 && left1 > 0) act1 = 1;
        end
        if (cyc >= 100) check("arb_budget", 32'(cyc), 32'd0);
        idle_inputs();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t vt[13];
        int   exp_fp[5];
        int   exp_rr[8];

        sel_b = 0;
        vt[0]  = mk(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        vt[1]  = mk(1, 0, 0, 32'h0, 1, A0,    0, 32'h0, 0, 32'h0);
        vt[2]  = mk(1, 0, 0, 32'h0, 1, A0,    0, 32'h0, 0, 32'h0);
        vt[3]  = mk(1, 0, 0, 32'h0, 1, A0,    0, 32'h0, 0, 32'h0);
        vt[4]  = mk(1, 0, 1, RD,    1, A0,    1, RD,    0, 32'h0);
        vt[5]  = mk(0, 0, 0, 32'h0, 0, A0,    0, 32'h0, 0, 32'h0);
        vt[6]  = mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        vt[7]  = mk(1, 1, 1, RD1,   1, A1,    0, 32'h0, 1, RD1);
        vt[8]  = mk(1, 0, 0, 32'h0, 0, A1,    0, 32'h0, 0, 32'h0);
        vt[9]  = mk(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        vt[10] = mk(1, 0, 1, RD,    1, A0,    1, RD,    0, 32'h0);
        vt[11] = mk(0, 0, 0, 32'h0, 0, A0,    0, 32'h0, 0, 32'h0);
        vt[12] = mk(0, 0, 1, RD,    0, 32'h0, 0, 32'h0, 0, 32'h0);
        exp_fp = '{0, 0, 0, 1, 1};
        exp_rr = '{0, 1, 0, 1, 0, 1, 0, 1};

        // Reset state
        do_reset();
        #3;
        check("rst_a_cyc", {31'b0, a_cyc}, 32'd0);
        check("rst_a_acks", {30'b0, a_m0_ack, a_m1_ack}, 32'd0);
        check("rst_a_flag", {31'b0, a_flag}, 32'd0);
        check("rst_a_cnt", {24'b0, a_cnt}, 32'd0);
        check("rst_b_cyc", {31'b0, b_cyc}, 32'd0);
        step();

        // Table: m0 read with 3-cycle slave latency, m1 routing, stray ack
        foreach (vt[i]) begin
            m0_cyc = vt[i].r0; m0_stb = vt[i].r0;
            m1_cyc = vt[i].r1; m1_stb = vt[i].r1;
            wbm_ack = vt[i].ack; wbm_rdata = vt[i].rdata;
            #3;
            check($sformatf("v%0d_cyc", i),  {31'b0, a_cyc},    {31'b0, vt[i].e_cyc});
            check($sformatf("v%0d_addr", i), a_addr,            vt[i].e_addr);
            check($sformatf("v%0d_ack0", i), {31'b0, a_m0_ack}, {31'b0, vt[i].e_a0});
            check($sformatf("v%0d_rd0", i),  a_m0_rdata,        vt[i].e_d0);
            check($sformatf("v%0d_ack1", i), {31'b0, a_m1_ack}, {31'b0, vt[i].e_a1});
            check($sformatf("v%0d_rd1", i),  a_m1_rdata,        vt[i].e_d1);
            step();
        end
        idle_inputs();

        // Fixed priority: m0 keeps winning while it has work
        do_reset();
        sel_b = 0;
        run_arb(3, 2);
        check("fp_count", 32'(grants.size()), 32'd5);
        foreach (exp_fp[i]) if (i < grants.size()) check($sformatf("fp_order%0d", i), 32'(grants[i]), 32'(exp_fp[i]));

        // Round robin: strict alternation starting with m0
        do_reset();
        sel_b = 1;
        run_arb(4, 4);
        check("rr_count", 32'(grants.size()), 32'd8);
        foreach (exp_rr[i]) if (i < grants.size()) check($sformatf("rr_order%0d", i), 32'(grants[i]), 32'(exp_rr[i]));
        sel_b = 0;

        // Watchdog: m1 read never acked
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 0;
        #3 check("tmo_idle_cyc", {31'b0, a_cyc}, 32'd0);
        step();
        for (int c = 1; c <= 8; c++) begin
            #3;
            check($sformatf("tmo_stall%0d_cyc", c), {31'b0, a_cyc}, 32'd1);
            check($sformatf("tmo_stall%0d_ack", c), {31'b0, a_m1_ack}, 32'd0);
            step();
        end
        #3;
        check("tmo_ack", {31'b0, a_m1_ack}, 32'd1);
        check("tmo_rdata", a_m1_rdata, 32'hDEAD_BEEF);
        check("tmo_wbm_cyc", {30'b0, a_cyc, a_stb}, 32'd0);
        check("tmo_m0_ack", {31'b0, a_m0_ack}, 32'd0);
        step();
        m1_cyc = 0; m1_stb = 0;
        #3;
        check("tmo_flag", {31'b0, a_flag}, 32'd1);
        check("tmo_cnt", {24'b0, a_cnt}, 32'd1);
        check("tmo_after_ack", {31'b0, a_m1_ack}, 32'd0);
        step();
        wbm_ack = 1; wbm_rdata = 32'h5555_5555;
        #3;
        check("late_ack_routed", {30'b0, a_m0_ack, a_m1_ack}, 32'd0);
        check("late_ack_rdata", a_m1_rdata, 32'd0);
        step();
        wbm_ack = 0; wbm_rdata = 32'h0;

        // Ack on the last allowed stall cycle completes normally
        m0_cyc = 1; m0_stb = 1;
        step();
        for (int c = 1; c <= 7; c++) begin
            #3 check($sformatf("edge_stall%0d_ack", c), {31'b0, a_m0_ack}, 32'd0);
            step();
        end
        wbm_ack = 1; wbm_rdata = 32'h0BAD_F00D;
        #3;
        check("edge_ack", {31'b0, a_m0_ack}, 32'd1);
        check("edge_rdata", a_m0_rdata, 32'h0BAD_F00D);
        step();
        wbm_ack = 0; wbm_rdata = 32'h0; m0_cyc = 0; m0_stb = 0;
        #3;
        check("edge_no_tmo_ack", {31'b0, a_m0_ack}, 32'd0);
        check("edge_cnt", {24'b0, a_cnt}, 32'd1);
        step();
        #3 check("edge_idle", {31'b0, a_cyc}, 32'd0);
        step();

        // Asynchronous reset in the middle of a granted cycle
        m0_cyc = 1; m0_stb = 1;
        step();
        #3 check("pre_rst_cyc", {31'b0, a_cyc}, 32'd1);
        wbm_ack = 1;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_cyc", {31'b0, a_cyc}, 32'd0);
        check("async_rst_ack", {30'b0, a_m0_ack, a_m1_ack}, 32'd0);
        check("async_rst_flag", {24'b0, a_cnt} | {31'b0, a_flag}, 32'd0);
        idle_inputs();
        m1_cyc = 1; m1_stb = 1;
        step();
        rst_n = 1'b1;
        #3 check("post_rst_idle", {31'b0, a_cyc}, 32'd0);
        step();
        #3;
        check("post_rst_gnt", {31'b0, a_cyc}, 32'd1);
        check("post_rst_addr", a_addr, A1);
        step();
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
